// File: rtl/regfile_wr_ctrl_pkg.sv
// Shared definitions for the register-file write-port controller.
package regfile_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned LAST_REG = 31;

    // Grant vector bit positions used by the arbiter and the controller.
    localparam int unsigned GNT_ALU = 0;
    localparam int unsigned GNT_MEM = 1;

    typedef enum logic {
        INIT,
        RUN
    } wr_state_t;

    typedef enum logic {
        SRC_ALU,
        SRC_MEM
    } wr_src_t;

endpackage

// File: rtl/regfile_wr_ctrl_if.sv
// Writeback request channels (ALU, MEM) and RegFile write-port drive.
interface regfile_wr_ctrl_if #(
    parameter int unsigned DATA_W = regfile_pkg::DATA_W,
    parameter int unsigned ADDR_W = regfile_pkg::ADDR_W
);

    // ALU writeback channel
    logic              AluValid;
    logic [ADDR_W-1:0] AluRd;
    logic [DATA_W-1:0] AluData;
    logic              AluReady;

    // Load writeback channel
    logic              MemValid;
    logic [ADDR_W-1:0] MemRd;
    logic [DATA_W-1:0] MemData;
    logic              MemReady;

    // RegFile write port and status
    logic [ADDR_W-1:0] RD;
    logic [DATA_W-1:0] WData;
    logic              RegWr;
    logic              InitDone;

    // Controller side
    modport slave (
        input  AluValid, AluRd, AluData,
        output AluReady,
        input  MemValid, MemRd, MemData,
        output MemReady,
        output RD, WData, RegWr, InitDone
    );

    // Writeback sources and register-file side
    modport master (
        output AluValid, AluRd, AluData,
        input  AluReady,
        output MemValid, MemRd, MemData,
        input  MemReady,
        input  RD, WData, RegWr, InitDone
    );

endinterface

// File: rtl/regfile_wr_ctrl_rr_arb2.sv
// Combinational two-way round-robin arbiter; the last-grant state is kept
// by the caller.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic       req_alu_i,
    input  logic       req_mem_i,
    input  wr_src_t    last_gnt_i,
    output logic [1:0] gnt_o
);

    // One-hot grant: a lone requester wins, a tie goes to the source not served last.
    always_comb begin
        gnt_o = '0;
        if (req_alu_i && req_mem_i) begin
            if (last_gnt_i == SRC_MEM) begin
                gnt_o[GNT_ALU] = 1'b1;
            end else begin
                gnt_o[GNT_MEM] = 1'b1;
            end
        end else if (req_alu_i) begin
            gnt_o[GNT_ALU] = 1'b1;
        end else if (req_mem_i) begin
            gnt_o[GNT_MEM] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_wr_ctrl.sv
// Register-file write-port controller: clears r1..LAST_REG after reset, then
// arbitrates ALU and load writebacks onto the single registered write port.
module regfile_wr_ctrl #(
    parameter int unsigned DATA_W   = regfile_pkg::DATA_W,
    parameter int unsigned ADDR_W   = regfile_pkg::ADDR_W,
    parameter int unsigned LAST_REG = regfile_pkg::LAST_REG
) (
    input  logic               Clk,
    input  logic               Reset_n,
    regfile_wr_ctrl_if.slave   bus
);

    import regfile_pkg::*;

    wr_state_t         state_q, state_d;
    logic [ADDR_W-1:0] init_ptr_q, init_ptr_d;
    wr_src_t           last_gnt_q, last_gnt_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              regwr_q, regwr_d;

    logic [1:0]        gnt;
    logic              run;
    logic              alu_xfer;
    logic              mem_xfer;

    rr_arb2 u_arb (
        .req_alu_i  (bus.AluValid),
        .req_mem_i  (bus.MemValid),
        .last_gnt_i (last_gnt_q),
        .gnt_o      (gnt)
    );

    // Readys are only offered once the clearing sweep has finished.
    always_comb begin
        run      = (state_q == RUN);
        alu_xfer = run && gnt[GNT_ALU];
        mem_xfer = run && gnt[GNT_MEM];
    end

    assign bus.AluReady = alu_xfer;
    assign bus.MemReady = mem_xfer;
    assign bus.RD       = rd_q;
    assign bus.WData    = wdata_q;
    assign bus.RegWr    = regwr_q;
    assign bus.InitDone = run;

    // Next-state: sweep r1..LAST_REG with zeros, then register accepted writebacks.
    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        last_gnt_d = last_gnt_q;
        rd_d       = rd_q;
        wdata_d    = wdata_q;
        regwr_d    = 1'b0;

        case (state_q)
            INIT: begin
                regwr_d = 1'b1;
                rd_d    = init_ptr_q;
                wdata_d = '0;
                if (init_ptr_q == ADDR_W'(LAST_REG)) begin
                    state_d = RUN;
                end else begin
                    init_ptr_d = init_ptr_q + ADDR_W'(1);
                end
            end
            RUN: begin
                if (alu_xfer) begin
                    rd_d       = bus.AluRd;
                    wdata_d    = bus.AluData;
                    regwr_d    = (bus.AluRd != '0);
                    last_gnt_d = SRC_ALU;
                end else if (mem_xfer) begin
                    rd_d       = bus.MemRd;
                    wdata_d    = bus.MemData;
                    regwr_d    = (bus.MemRd != '0);
                    last_gnt_d = SRC_MEM;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // State and write-port registers; reset favours ALU on the first tie.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= INIT;
            init_ptr_q <= ADDR_W'(1);
            last_gnt_q <= SRC_MEM;
            rd_q       <= '0;
            wdata_q    <= '0;
            regwr_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
            last_gnt_q <= last_gnt_d;
            rd_q       <= rd_d;
            wdata_q    <= wdata_d;
            regwr_q    <= regwr_d;
        end
    end

endmodule

// File: tb/tb_regfile_wr_ctrl.sv
// Directed bench for regfile_wr_ctrl with a scoreboard of expected write-port values.
module tb_regfile_wr_ctrl;

    import regfile_pkg::*;

    logic Clk     = 1'b0;
    logic Reset_n = 1'b0;

    always #5 Clk = ~Clk;

    regfile_wr_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_wr_ctrl #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .LAST_REG (LAST_REG)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic              wr;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t sbq[$];

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit                m_run;
    int unsigned       m_ptr;
    bit                m_last_mem;
    logic [ADDR_W-1:0] m_rd;
    logic [DATA_W-1:0] m_wd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run      = 1'b0;
        m_ptr      = 1;
        m_last_mem = 1'b1;
        m_rd       = '0;
        m_wd       = '0;
        sbq.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd"},        bus.RD,       '0);
        chk({tag, "_wdata"},     bus.WData,    '0);
        chk({tag, "_regwr"},     bus.RegWr,    '0);
        chk({tag, "_initdone"},  bus.InitDone, '0);
        chk({tag, "_aluready"},  bus.AluReady, '0);
        chk({tag, "_memready"},  bus.MemReady, '0);
    endtask

    // One clock cycle: check readys, predict the next write-port value, clock, compare.
    task automatic cycle();
        logic er_a;
        logic er_m;
        exp_t e;
        #1;
        er_a = 1'b0;
        er_m = 1'b0;
        if (m_run) begin
            if (bus.AluValid && bus.MemValid) begin
                er_a = m_last_mem;
                er_m = !m_last_mem;
            end else begin
                er_a = bus.AluValid;
                er_m = bus.MemValid;
            end
        end
        chk("alu_ready", bus.AluReady, er_a);
        chk("mem_ready", bus.MemReady, er_m);
        chk("init_done", bus.InitDone, m_run);

        if (!m_run) begin
            e = '{1'b1, ADDR_W'(m_ptr), '0};
            m_rd = ADDR_W'(m_ptr);
            m_wd = '0;
            if (m_ptr == LAST_REG) m_run = 1'b1;
            else m_ptr++;
        end else if (er_a) begin
            e = '{(bus.AluRd != '0), bus.AluRd, bus.AluData};
            m_rd = bus.AluRd;
            m_wd = bus.AluData;
            m_last_mem = 1'b0;
        end else if (er_m) begin
            e = '{(bus.MemRd != '0), bus.MemRd, bus.MemData};
            m_rd = bus.MemRd;
            m_wd = bus.MemData;
            m_last_mem = 1'b1;
        end else begin
            e = '{1'b0, m_rd, m_wd};
        end
        sbq.push_back(e);

        @(posedge Clk);
        #1;
        e = sbq.pop_front();
        chk("regwr", bus.RegWr, e.wr);
        chk("rd",    bus.RD,    e.rd);
        chk("wdata", bus.WData, e.data);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int n;

        bus.AluValid = 1'b0;
        bus.AluRd    = '0;
        bus.AluData  = '0;
        bus.MemValid = 1'b0;
        bus.MemRd    = '0;
        bus.MemData  = '0;
        model_reset();

        // Reset held with an ALU request already pending
        bus.AluValid = 1'b1;
        bus.AluRd    = 5'd5;
        bus.AluData  = 32'hDEADBEEF;
        repeat (2) @(posedge Clk);
        #1;
        chk_reset_outputs("in_reset");
        Reset_n = 1'b1;

        // Sweep r1..r31 while the ALU request is held off
        repeat (31) cycle();
        // InitDone cycle: ALU accepted, write visible next cycle
        cycle();
        bus.AluValid = 1'b0;
        cycle();

        // Load writeback to x0 is accepted but not written
        bus.MemValid = 1'b1;
        bus.MemRd    = '0;
        bus.MemData  = 32'hFFFFFFFF;
        cycle();
        bus.MemValid = 1'b0;
        cycle();

        // Constant contention: ALU r3 / MEM r4 alternate, ALU first
        bus.AluValid = 1'b1;
        bus.AluRd    = 5'd3;
        bus.AluData  = 32'h11;
        bus.MemValid = 1'b1;
        bus.MemRd    = 5'd4;
        bus.MemData  = 32'h22;
        repeat (4) cycle();
        bus.AluValid = 1'b0;
        bus.MemValid = 1'b0;
        cycle();

        // Back-to-back single-source writes
        bus.MemValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.MemRd   = ADDR_W'(20 + i);
            bus.MemData = 32'hA5A50000 + 32'(i);
            cycle();
        end
        bus.MemValid = 1'b0;
        cycle();

        // Reset mid-run, then reset again mid-init at RD=10
        Reset_n = 1'b0;
        #1;
        chk_reset_outputs("run_reset");
        model_reset();
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        repeat (10) cycle();
        chk("rd_before_pulse", bus.RD, 10);
        Reset_n = 1'b0;
        #1;
        chk_reset_outputs("init_reset");
        model_reset();
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        n = 0;
        while (!bus.InitDone && n < 40) begin
            cycle();
            n++;
        end
        chk("init_restart_cycles", n, 31);
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
